// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - shared DDR read-path widths, client id type and defaults
package ddr_pkg;

    localparam int DDR_ADDR_W              = 24;
    localparam int DDR_DATA_W              = 32;
    localparam int DEFAULT_MAX_OUTSTANDING = 8;

    // One bit is enough to name either of the two read clients.
    typedef logic client_id_t;

    localparam client_id_t CLIENT0 = 1'b0;
    localparam client_id_t CLIENT1 = 1'b1;

endpackage

// File: rtl/tag_fifo.sv
// rtl/tag_fifo.sv - synchronous show-ahead FIFO holding the client tag of each read in flight
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-high reset (flushes contents)
//   push, din          write one entry; ignored when full
//   pop                discard head entry; ignored when empty
//   dout               head entry, valid whenever empty is low
//   full, empty        occupancy flags
//   count              number of entries held (0..DEPTH)
module tag_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign dout  = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ddr_read_arbiter.sv
// rtl/ddr_read_arbiter.sv - two-client round-robin arbiter for the shared DDR read port
//
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-high reset
//   cX_address, cX_read          client X request (held until accepted)
//   cX_waitrequest               client X stall
//   cX_readdatavalid, cX_readdata   returned word for client X (data shared by both)
//   ddr_read_address, ddr_read_read, ddr_read_waitrequest   DDR issue side
//   ddr_read_readdatavalid, ddr_read_readdata               DDR return side
//   outstanding                  reads accepted by DDR and not yet returned
//   orphan_error                 sticky: a return arrived with nothing outstanding
module ddr_read_arbiter
    import ddr_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
    parameter int ADDR_W          = DDR_ADDR_W,
    parameter int DATA_W          = DDR_DATA_W
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [ADDR_W-1:0]                  c0_address,
    input  logic                               c0_read,
    output logic                               c0_waitrequest,
    output logic                               c0_readdatavalid,
    output logic [DATA_W-1:0]                  c0_readdata,
    input  logic [ADDR_W-1:0]                  c1_address,
    input  logic                               c1_read,
    output logic                               c1_waitrequest,
    output logic                               c1_readdatavalid,
    output logic [DATA_W-1:0]                  c1_readdata,
    output logic [ADDR_W-1:0]                  ddr_read_address,
    output logic                               ddr_read_read,
    input  logic                               ddr_read_waitrequest,
    input  logic                               ddr_read_readdatavalid,
    input  logic [DATA_W-1:0]                  ddr_read_readdata,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               orphan_error
);

    client_id_t last;
    client_id_t owner;
    client_id_t sel;
    client_id_t head;
    logic       locked;
    logic       full;
    logic       empty;
    logic       sel_read;
    logic       accept;
    logic       pop;
    logic       orphan;

    // A stalled grant is locked so the DDR side sees a stable request; otherwise
    // a lone requester wins, and a tie goes to whoever was not served last.
    always_comb begin
        sel = ~last;
        if (locked) begin
            sel = owner;
        end else if (c0_read && !c1_read) begin
            sel = CLIENT0;
        end else if (c1_read && !c0_read) begin
            sel = CLIENT1;
        end
    end

    assign sel_read         = (sel == CLIENT1) ? c1_read : c0_read;
    assign ddr_read_read    = sel_read && !full;
    assign ddr_read_address = (sel == CLIENT1) ? c1_address : c0_address;

    assign c0_waitrequest = !((sel == CLIENT0) && c0_read) || ddr_read_waitrequest || full;
    assign c1_waitrequest = !((sel == CLIENT1) && c1_read) || ddr_read_waitrequest || full;

    assign accept = ddr_read_read && !ddr_read_waitrequest;
    assign pop    = ddr_read_readdatavalid && !empty;
    assign orphan = ddr_read_readdatavalid && empty;

    // Returns come back in issue order, so the FIFO head names the owner.
    assign c0_readdatavalid = pop && (head == CLIENT0);
    assign c1_readdatavalid = pop && (head == CLIENT1);
    assign c0_readdata      = ddr_read_readdata;
    assign c1_readdata      = ddr_read_readdata;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last         <= CLIENT1;
            owner        <= CLIENT0;
            locked       <= 1'b0;
            orphan_error <= 1'b0;
        end else begin
            if (accept) begin
                last   <= sel;
                locked <= 1'b0;
            end else if (ddr_read_read && ddr_read_waitrequest) begin
                locked <= 1'b1;
                owner  <= sel;
            end
            if (orphan) begin
                orphan_error <= 1'b1;
            end
        end
    end

    // The FIFO count is the in-flight total; full is sampled from the
    // registered count, so a same-cycle return only frees a slot next cycle.
    tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1)
    ) u_tag_fifo (
        .clock (clock),
        .reset (reset),
        .push  (accept),
        .din   (sel),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (outstanding)
    );

endmodule

// File: doc/ddr_read_arbiter.md
# ddr_read_arbiter

Shares the single DDR3 read interface (64 MB word-addressed window, Avalon-MM pipelined-read style) between two independent read clients, e.g. the playback reader and the verification/readback path. Round-robin arbitration on issue, in-order tag FIFO to route each returning word to the client that requested it. Sits between the client read engines and the ddr_read_* port of the top level. Single clock domain: everything is clocked by `clock`.

## Interface
Parameters:
- MAX_OUTSTANDING, 8: tag FIFO depth, power of two, 2..64; maximum reads in flight.
- ADDR_W, 24: word address width.
- DATA_W, 32: data width.

Ports:
- clock  in  1  application clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high.
- c0_address  in  ADDR_W  client 0 word address.
- c0_read  in  1  client 0 read request, held until accepted.
- c0_waitrequest  out  1  client 0 stall.
- c0_readdatavalid  out  1  returned word belongs to client 0.
- c0_readdata  out  DATA_W  returned data.
- c1_address, c1_read, c1_waitrequest, c1_readdatavalid, c1_readdata: same for client 1.
- ddr_read_address  out  ADDR_W  to DDR.
- ddr_read_read  out  1  to DDR.
- ddr_read_waitrequest  in  1  from DDR.
- ddr_read_readdatavalid  in  1  from DDR.
- ddr_read_readdata  in  DATA_W  from DDR.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  reads in flight.
- orphan_error  out  1  sticky: readdatavalid seen with no read outstanding.

## Operation
- Registers: `last` (last accepted client), `locked`/`owner` (stalled grant), tag FIFO (1-bit client id per entry), `outstanding`, `orphan_error`.
- Select: if `locked`, sel = `owner`. Else if only one client requests, sel = that client. If both, sel = client not equal to `last`.
- Issue: ddr_read_read = sel client's read AND !full. ddr_read_address = sel client's address.
- cX_waitrequest = !(sel==X AND cX_read) OR ddr_read_waitrequest OR full.
- Accept = ddr_read_read AND !ddr_read_waitrequest: push sel into FIFO, `last` <= sel, `locked` <= 0.
- Stall: ddr_read_read AND ddr_read_waitrequest sets `locked`=1, `owner`=sel. Address/read to DDR stay stable until accepted. The other client cannot preempt.
- Return: on ddr_read_readdatavalid with FIFO non-empty: pop; cX_readdatavalid asserted for X = head tag. Both cX_readdata driven by ddr_read_readdata at all times.
- Return with FIFO empty: no client valid, word dropped, orphan_error <= 1 until reset.
- outstanding = +1 on accept, -1 on return, unchanged when both occur in the same cycle.
- Full (outstanding == MAX_OUTSTANDING): ddr_read_read forced 0, both clients stalled. A same-cycle return does not unblock issue until the next cycle.

## Timing
- Reset values: ddr_read_read 0, cX_waitrequest 1 (full=0 but no requests), cX_readdatavalid 0, outstanding 0, orphan_error 0, `last`=1 (client 0 wins first tie), `locked`=0, FIFO empty.
- Issue path is combinational: zero added cycles. A request present in cycle N reaches DDR in cycle N.
- Return path is combinational: zero added cycles from ddr_read_readdatavalid to cXreaddatavalid.
- Back-to-back reads: one accept per cycle. With both clients requesting continuously, grants alternate 0,1,0,1.
- Reset mid-operation: FIFO flushed, in-flight returns arriving after reset are orphans and set orphan_error.

## Structure
- Shared package ddr_pkg: DDR_ADDR_W=24, DDR_DATA_W=32, client id type (1 bit), default MAX_OUTSTANDING.
- Sub-module tag_fifo (synchronous, show-ahead, DEPTH/WIDTH params, full/empty/count). Count drives `outstanding`.
- Arbiter logic in the top of the block, roughly 150 RTL lines plus the FIFO.

## Test plan
- Single client: c0 reads addr 0x000010..0x000013, DDR returns 0xA0..0xA3 after 5 cycles -> c0_readdatavalid ×4 with data in order, c1_readdatavalid never high, outstanding peaks at 4 then returns to 0.
- Contention: c0 and c1 both read continuously from reset -> DDR sees c0,c1,c0,c1 addresses. Returns are routed by tag, e.g. the 2nd return goes to c1.
- Stall lock: ddr_read_waitrequest high 3 cycles while c0 is granted, c1 raises read in stall cycle 2 -> address stays c0's, c0 accepted first, c1 next.
- Full: MAX_OUTSTANDING=8, no returns, 10 requests -> exactly 8 accepted, both waitrequests high, outstanding=8. One return -> next request accepted the following cycle.
- Simultaneous accept and return at outstanding=3 -> outstanding stays 3, routing correct.
- Orphan/reset: assert reset with 2 outstanding, then 2 returns -> no cXreaddatavalid, orphan_error=1 until the next reset.
